result_display_scanner: RTL

Downstream consumer of the processor's 17-bit display word and `done` flag. Captures the result on each rising edge of `done` and drives a four-digit, time-multiplexed, active-low seven-segment display with the 16-bit value in hexadecimal. Bit 16, the carry/overflow flag, blinks the decimal point. It replaces the static two-digit decoder path when the board exposes a scanned four-digit display.

---
 rtl/result_display_scanner.sv | 118 +++++++++++
 1 files changed

// File: rtl/result_display_scanner.sv
// Captures the processor's 17-bit result on each rising edge of done and shows it
// as four hex digits on a scanned, active-low seven-segment display with a blinking overflow point.
module result_display_scanner #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [16:0] data_in,
    input  logic        done,
    input  logic        live,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        valid
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [9:0]    BLINK_LAST = 10'(BLINK_DIV - 1);

    logic          done_q,      done_d;
    logic [16:0]   value_q,     value_d;
    logic          valid_q,     valid_d;
    logic [SW-1:0] scan_cnt_q,  scan_cnt_d;
    logic [1:0]    digit_q,     digit_d;
    logic [9:0]    blink_cnt_q, blink_cnt_d;
    logic          blink_q,     blink_d;
    logic [6:0]    seg_q,       seg_d;
    logic [3:0]    an_q,        an_d;
    logic          dp_q,        dp_d;

    logic          capture;
    logic          term;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        done_d      = done;
        capture     = live | (done & ~done_q);
        value_d     = capture ? data_in : value_q;
        valid_d     = valid_q | capture;

        term        = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d  = term ? '0 : scan_cnt_q + 1'b1;
        digit_d     = term ? digit_q + 2'd1 : digit_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        // A full scan round completes when digit 3 hands over to digit 0
        if (term && (digit_q == 2'd3)) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 10'd1;
            end
        end

        // Outputs look one step ahead so they line up with the state being entered
        nibble = value_d[{digit_d, 2'b00} +: 4];
        seg_d  = valid_d ? hex_to_seg(nibble) : 7'b0111111;
        dp_d   = ~((digit_d == 2'd0) & valid_d & value_d[16] & blink_d);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_an
        assign an_d[gi] = (digit_d != 2'(gi));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            done_q      <= 1'b0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            scan_cnt_q  <= '0;
            digit_q     <= 2'd0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            seg_q       <= 7'b1111111;
            an_q        <= 4'b1111;
            dp_q        <= 1'b1;
        end else begin
            done_q      <= done_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign dp    = dp_q;
    assign valid = valid_q;
endmodule
